norm32_seq: RTL and testbench

Multi-cycle 32-bit normalizer and the inverse of the SHIFT32 barrel shifter. Given a shifted word, it finds how far the word can shift toward one end before a 1 would be lost, then returns the normalized word and that distance. Passing the returned `CNT` back to SHIFT32 as `S`, with the opposite `LnR`, reproduces the original `D`. The block sits beside SHIFT32 in the ALU datapath and serves the count-leading/trailing-zeros and normalize operations through a START/DONE handshake.

---
 rtl/norm32_seq_pkg.sv | 25 ++
 rtl/norm32_seq_step.sv | 34 +++
 rtl/norm32_seq.sv | 137 +++++++++++++
 tb/tb_norm32_seq.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/norm32_seq_pkg.sv
// Shared ALU constants and the normalizer's state encoding.
//   DATA_WIDTH  : datapath width (32)
//   SHAMT_WIDTH : width of a shift amount / step distance (5)
//   NORM_STEPS  : binary-search steps, log2(DATA_WIDTH) (5)
//   CNT_WIDTH   : width of the normalize count, 0..32 (6)
package norm32_seq_pkg;

  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned SHAMT_WIDTH = 5;
  localparam int unsigned NORM_STEPS  = 5;
  localparam int unsigned CNT_WIDTH   = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Step distance for search step s: 16, 8, 4, 2, 1.
  function automatic logic [SHAMT_WIDTH-1:0] step_k(input logic [2:0] s);
    return SHAMT_WIDTH'(16) >> s;
  endfunction

endpackage

// File: rtl/norm32_seq_step.sv
// norm_step32: one combinational binary-search step of the normalizer.
//   w      in  32 : current working word
//   k      in  5  : step distance (16, 8, 4, 2 or 1)
//   LnR    in  1  : 1 = shift toward bit 31, 0 = toward bit 0
//   w_next out 32 : working word after the step
//   hit    out 1  : the k bits at the leading end were all zero, so the shift happened
module norm_step32
  import norm32_seq_pkg::*;
(
  input  logic [DATA_WIDTH-1:0]  w,
  input  logic [SHAMT_WIDTH-1:0] k,
  input  logic                   LnR,
  output logic [DATA_WIDTH-1:0]  w_next,
  output logic                   hit
);

  logic [5:0] rsh;
  logic       hi_zero;
  logic       lo_zero;

  // Shifting by (32-k) isolates the top k bits (right shift) or the
  // bottom k bits (left shift) without a variable-width part select.
  always_comb begin
    rsh     = 6'(DATA_WIDTH) - {1'b0, k};
    hi_zero = ((w >> rsh) == '0);
    lo_zero = ((w << rsh) == '0);
    hit     = LnR ? hi_zero : lo_zero;
    w_next  = w;
    if (hit) begin
      w_next = LnR ? (w << k) : (w >> k);
    end
  end

endmodule

// File: rtl/norm32_seq.sv
// norm32_seq: multi-cycle 32-bit normalizer (inverse of SHIFT32).
// A START accepted in IDLE or DONE captures D/LnR; LOAD primes the working
// registers, five RUN cycles perform a binary search, DONE pulses with the
// result. Outputs Y/CNT/ZERO update only on the RUN->DONE edge.
//   CLK   in  1  : clock, rising edge
//   RST   in  1  : synchronous active-high reset
//   START in  1  : request, honoured only in IDLE or DONE
//   D     in  32 : operand
//   LnR   in  1  : 1 = count leading zeros, 0 = count trailing zeros
//   Y     out 32 : normalized word
//   CNT   out 6  : shift distance 0..32
//   ZERO  out 1  : operand was zero
//   BUSY  out 1  : high in LOAD and RUN
//   DONE  out 1  : one-cycle completion pulse
module norm32_seq
  import norm32_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH,
  parameter int unsigned STEPS = NORM_STEPS
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [WIDTH-1:0]     D,
  input  logic                 LnR,
  output logic [WIDTH-1:0]     Y,
  output logic [CNT_WIDTH-1:0] CNT,
  output logic                 ZERO,
  output logic                 BUSY,
  output logic                 DONE
);

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0]       d_cap;
  logic                   lnr_r;
  logic [WIDTH-1:0]       w;
  logic [CNT_WIDTH-1:0]   c;
  logic [2:0]             s;
  logic                   z_r;

  logic                   accept;
  logic                   last_step;
  logic [SHAMT_WIDTH-1:0] k;
  logic [WIDTH-1:0]       w_next;
  logic                   hit;
  logic [CNT_WIDTH-1:0]   c_step;

  norm_step32 u_step (
    .w      (w),
    .k      (k),
    .LnR    (lnr_r),
    .w_next (w_next),
    .hit    (hit)
  );

  always_comb begin
    accept    = START && (state == ST_IDLE || state == ST_DONE);
    last_step = (s == 3'(STEPS - 1));
    k         = step_k(s);
    c_step    = c + (hit ? {1'b0, k} : '0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    BUSY       = 1'b0;
    DONE       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (START) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        BUSY       = 1'b1;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        BUSY = 1'b1;
        if (last_step) state_next = ST_DONE;
      end
      ST_DONE: begin
        DONE       = 1'b1;
        state_next = START ? ST_LOAD : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      d_cap <= '0;
      lnr_r <= 1'b0;
      w     <= '0;
      c     <= '0;
      s     <= '0;
      z_r   <= 1'b0;
      Y     <= '0;
      CNT   <= '0;
      ZERO  <= 1'b0;
    end else begin
      if (accept) begin
        d_cap <= D;
        lnr_r <= LnR;
      end
      case (state)
        ST_LOAD: begin
          w   <= d_cap;
          c   <= '0;
          z_r <= (d_cap == '0);
          s   <= '0;
        end
        ST_RUN: begin
          w <= w_next;
          c <= c_step;
          s <= s + 3'd1;
          // The last step's result goes straight to the outputs; a zero
          // operand searches to c=31, which is overridden to 32.
          if (last_step) begin
            Y    <= z_r ? '0 : w_next;
            CNT  <= z_r ? CNT_WIDTH'(WIDTH) : c_step;
            ZERO <= z_r;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_norm32_seq.sv
module tb_norm32_seq;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [31:0] D;
  logic        LnR;
  logic [31:0] Y;
  logic [5:0]  CNT;
  logic        ZERO;
  logic        BUSY;
  logic        DONE;

  typedef struct {
    logic [31:0] y;
    logic [5:0]  cnt;
    logic        zero;
  } exp_t;

  exp_t        q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  norm32_seq #(.WIDTH(32), .STEPS(5)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .D     (D),
    .LnR   (LnR),
    .Y     (Y),
    .CNT   (CNT),
    .ZERO  (ZERO),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Reference: shift one bit at a time until the target end holds a 1.
  function automatic exp_t model(input logic [31:0] d, input logic lnr);
    exp_t e;
    e.y    = d;
    e.cnt  = '0;
    e.zero = (d == 32'h0);
    if (e.zero) begin
      e.y   = '0;
      e.cnt = 6'd32;
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (lnr ? e.y[31] : e.y[0]) break;
        e.y   = lnr ? (e.y << 1) : (e.y >> 1);
        e.cnt = e.cnt + 6'd1;
      end
    end
    return e;
  endfunction

  task automatic do_op(input logic [31:0] d, input logic lnr, input bit poke, output exp_t got);
    int   lat;
    exp_t e;
    @(negedge CLK);
    START = 1'b1; D = d; LnR = lnr;
    q.push_back(model(d, lnr));
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
      if (poke && lat == 3) begin
        START = 1'b1; D = ~d; LnR = ~lnr;
      end else begin
        START = 1'b0; D = $urandom; LnR = 1'($urandom);
      end
    end while (!DONE && lat < 20);
    chk("latency", 32'(lat), 32'd7);
    chk("done_pulse", {31'b0, DONE}, 32'd1);
    chk("busy_at_done", {31'b0, BUSY}, 32'd0);
    if (q.size() > 0) e = q.pop_front();
    else begin e.y = 'x; e.cnt = 'x; e.zero = 1'bx; end
    got.y = Y; got.cnt = CNT; got.zero = ZERO;
    chk("y", Y, e.y);
    chk("cnt", {26'b0, CNT}, {26'b0, e.cnt});
    chk("zero", {31'b0, ZERO}, {31'b0, e.zero});
  endtask

  initial begin
    exp_t        g;
    exp_t        last;
    logic [31:0] d;

    RST = 1'b1; START = 1'b0; D = '0; LnR = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_y", Y, 32'h0);
    chk("rst_cnt", {26'b0, CNT}, 32'd0);
    chk("rst_zero", {31'b0, ZERO}, 32'd0);
    chk("rst_busy", {31'b0, BUSY}, 32'd0);
    chk("rst_done", {31'b0, DONE}, 32'd0);
    RST = 1'b0;

    // Directed cases
    do_op(32'h0000_0001, 1'b1, 1'b0, g);
    chk("dir_clz1_y", g.y, 32'h8000_0000);
    chk("dir_clz1_cnt", {26'b0, g.cnt}, 32'd31);
    do_op(32'h8000_0000, 1'b0, 1'b0, g);
    chk("dir_ctz_y", g.y, 32'h0000_0001);
    chk("dir_ctz_cnt", {26'b0, g.cnt}, 32'd31);
    do_op(32'hFFFF_FFFF, 1'b1, 1'b0, g);
    chk("dir_ones_cnt", {26'b0, g.cnt}, 32'd0);
    do_op(32'h0000_0000, 1'b1, 1'b0, g);
    chk("dir_zero_l", {26'b0, g.cnt}, 32'd32);
    do_op(32'h0000_0000, 1'b0, 1'b0, g);
    chk("dir_zero_r", {g.zero, 25'b0, g.cnt}, {1'b1, 25'b0, 6'd32});
    do_op(32'h00F0_0000, 1'b1, 1'b0, g);
    chk("dir_f0_y", g.y, 32'hF000_0000);
    chk("dir_f0_cnt", {26'b0, g.cnt}, 32'd8);
    chk("dir_f0_roundtrip", g.y >> g.cnt, 32'h00F0_0000);

    // START pulsed while busy is ignored; no second DONE follows
    do_op(32'h0000_0300, 1'b0, 1'b1, g);
    chk("poke_cnt", {26'b0, g.cnt}, 32'd8);
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      chk("poke_no_done", {31'b0, DONE}, 32'd0);
      chk("poke_hold_y", Y, 32'h0000_0003);
    end

    // START held high: accepted in IDLE at 0, then in each DONE cycle
    last = g;
    for (int i = 0; i < 28; i++) begin
      @(negedge CLK);
      chk("hold_done", {31'b0, DONE}, {31'b0, (i == 7 || i == 14 || i == 21)});
      chk("hold_busy", {31'b0, BUSY}, {31'b0, (i > 0 && i < 21 && (i % 7) != 0)});
      if (DONE) begin
        if (q.size() > 0) last = q.pop_front();
        chk("hold_y", Y, last.y);
        chk("hold_cnt", {26'b0, CNT}, {26'b0, last.cnt});
      end else begin
        chk("hold_stable_y", Y, last.y);
        chk("hold_stable_cnt", {26'b0, CNT}, {26'b0, last.cnt});
      end
      START = (i <= 20);
      D     = ($urandom >> (i % 29)) | 32'h1;
      LnR   = i[0];
      if (i == 0 || i == 7 || i == 14) q.push_back(model(D, LnR));
    end
    START = 1'b0;
    q.delete();

    // Reset mid-operation aborts it
    do_op(32'h0001_0000, 1'b1, 1'b0, g);
    @(negedge CLK);
    START = 1'b1; D = 32'h0000_1234; LnR = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge CLK);
      START = 1'b0;
    end
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("abort_y", Y, 32'h0);
    chk("abort_cnt", {26'b0, CNT}, 32'd0);
    chk("abort_busy", {31'b0, BUSY}, 32'd0);
    chk("abort_done", {31'b0, DONE}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("abort_idle", {30'b0, BUSY, DONE}, 32'd0);
    end
    do_op(32'h0000_1234, 1'b1, 1'b0, g);
    chk("after_abort_cnt", {26'b0, g.cnt}, 32'd19);

    // Random round trips in both directions
    for (int i = 0; i < 1000; i++) begin
      d = $urandom;
      if (d == 32'h0) d = 32'h1;
      do_op(d, 1'b1, 1'b0, g);
      chk("rt_l", g.y >> g.cnt, d);
      do_op(d, 1'b0, 1'b0, g);
      chk("rt_r", g.y << g.cnt, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
